// File: rtl/bt_cmd_ctrl_if.sv
// Byte-stream input and player-control outputs of bt_cmd_ctrl.
// master: uart_rx side / top level, slave: the command controller.
interface bt_cmd_ctrl_if;
   // i_rx_data is valid while i_rx_done is high; a byte is taken on the first cycle
   // of each i_rx_done assertion and there is no back-pressure toward uart_rx.
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       o_left;
   logic       o_right;
   logic       o_fire;
   logic       o_start;
   logic       o_link_up;
   logic       o_pkt_ok;
   logic       o_pkt_err;

   modport master (
      output i_rx_data, i_rx_done,
      input  o_left, o_right, o_fire, o_start, o_link_up, o_pkt_ok, o_pkt_err
   );

   modport slave (
      input  i_rx_data, i_rx_done,
      output o_left, o_right, o_fire, o_start, o_link_up, o_pkt_ok, o_pkt_err
   );
endinterface

// File: rtl/bt_cmd_ctrl.sv
// Frames uart_rx bytes into SYNC/CMD/CHK packets and drives held player controls.
// BT_CMD_CTRL_FIRE_PULSE_EN turns o_fire into a one-cycle pulse on a new fire press.
module bt_cmd_ctrl #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         BYTE_TO_CYC = 120000,
   parameter int         HOLD_TO_CYC = 1200000
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   bt_cmd_ctrl_if.slave bus,
   output logic [1:0]   o_state
);
   localparam int BW = $clog2(BYTE_TO_CYC);
   localparam int HW = $clog2(HOLD_TO_CYC);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TO_CYC - 1);
   localparam logic [BW-1:0] BYTE_EXP  = BW'(BYTE_TO_CYC - 2);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TO_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_GOT_SYNC = 2'd1,
      S_GOT_CMD  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_done_q;
   logic [3:0]      r_cmd;
   logic [BW-1:0]   r_byte_cnt;
   logic [HW-1:0]   r_hold_cnt;
   logic            r_left;
   logic            r_right;
   logic            r_fire;
   logic            r_start;
   logic            r_link_up;
   logic            r_pkt_ok;
   logic            r_pkt_err;
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
   logic            r_prev_fire;
`endif

   logic            w_byte_evt;
   logic            w_byte_to;
   logic            w_hold_to;
   logic            w_accept;
   logic            w_err;
   logic            w_cmd_load;
   logic [7:0]      w_chk;

   assign w_byte_evt = bus.i_rx_done & ~r_done_q;
   // The error pulse lands on the edge where the gap counter reaches BYTE_TO_CYC-1.
   assign w_byte_to  = (r_state != S_IDLE) && (r_byte_cnt == BYTE_EXP);
   assign w_hold_to  = r_link_up && (r_hold_cnt == HOLD_LAST);
   assign w_chk      = {4'hF, ~r_cmd};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_err       = 1'b0;
      w_cmd_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_byte_evt && (bus.i_rx_data == SYNC_BYTE)) w_state_nxt = S_GOT_SYNC;
         end
         S_GOT_SYNC: begin
            if (w_byte_evt) begin
               if (bus.i_rx_data == SYNC_BYTE) begin
                  w_state_nxt = S_GOT_SYNC;
               end else if (bus.i_rx_data[7:4] == 4'h0) begin
                  w_cmd_load  = 1'b1;
                  w_state_nxt = S_GOT_CMD;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_byte_to) begin
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_GOT_CMD: begin
            if (w_byte_evt) begin
               if (bus.i_rx_data == w_chk) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = (bus.i_rx_data == SYNC_BYTE) ? S_GOT_SYNC : S_IDLE;
               end
            end else if (w_byte_to) begin
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_done_q    <= 1'b0;
         r_cmd       <= 4'h0;
         r_byte_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_left      <= 1'b0;
         r_right     <= 1'b0;
         r_fire      <= 1'b0;
         r_start     <= 1'b0;
         r_link_up   <= 1'b0;
         r_pkt_ok    <= 1'b0;
         r_pkt_err   <= 1'b0;
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
         r_prev_fire <= 1'b0;
`endif
      end else begin
         r_done_q  <= bus.i_rx_done;
         r_pkt_ok  <= w_accept;
         r_pkt_err <= w_err;
         if (w_cmd_load) r_cmd <= bus.i_rx_data[3:0];

         if ((w_state_nxt == S_IDLE) || w_byte_evt) r_byte_cnt <= '0;
         else if (r_byte_cnt != BYTE_LAST)          r_byte_cnt <= r_byte_cnt + BW'(1);

         // An accept in the hold-expiry cycle takes priority and reloads the controls.
         if (w_accept) begin
            r_link_up  <= 1'b1;
            r_hold_cnt <= '0;
            r_left     <= r_cmd[0] & ~r_cmd[1];
            r_right    <= r_cmd[1] & ~r_cmd[0];
            r_start    <= r_cmd[3];
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
            r_fire      <= r_cmd[2] & ~r_prev_fire;
            r_prev_fire <= r_cmd[2];
`else
            r_fire     <= r_cmd[2];
`endif
         end else if (w_hold_to) begin
            r_link_up  <= 1'b0;
            r_hold_cnt <= '0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_fire     <= 1'b0;
            r_start    <= 1'b0;
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
            r_prev_fire <= 1'b0;
`endif
         end else begin
            if (r_link_up && (r_hold_cnt != HOLD_LAST)) r_hold_cnt <= r_hold_cnt + HW'(1);
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
            r_fire <= 1'b0;
`endif
         end
      end
   end

   assign bus.o_left    = r_left;
   assign bus.o_right   = r_right;
   assign bus.o_fire    = r_fire;
   assign bus.o_start   = r_start;
   assign bus.o_link_up = r_link_up;
   assign bus.o_pkt_ok  = r_pkt_ok;
   assign bus.o_pkt_err = r_pkt_err;
   assign o_state       = r_state;
endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl: timestamp-based packet model checked every cycle,
// a scoreboard of accepted commands, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_bt_cmd_ctrl;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         BYTE_TO = 50;
   localparam int         HOLD_TO = 200;
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
   localparam logic [4:0] CTRL_MASK = 5'b11011;
`else
   localparam logic [4:0] CTRL_MASK = 5'b11111;
`endif

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       chk_en = 1'b0;
   logic [1:0] dbg_state;
   int         tb_cyc = 0;

   bt_cmd_ctrl_if bus();

   bt_cmd_ctrl #(
      .SYNC_BYTE   (SYNC),
      .BYTE_TO_CYC (BYTE_TO),
      .HOLD_TO_CYC (HOLD_TO)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- bookkeeping ----------------
   int         checks = 0;
   int         failures = 0;
   int         ok_cnt = 0;
   int         err_cnt = 0;
   int         fire_cnt = 0;
   int         last_ok_cyc = 0;
   int         last_evt_cyc = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] ctrl_vec();
      return {bus.o_link_up, bus.o_start, bus.o_fire, bus.o_right, bus.o_left};
   endfunction

   task automatic check_ctrl(input string name, input logic [4:0] exp);
      check(name, 16'(ctrl_vec() & CTRL_MASK), 16'(exp & CTRL_MASK));
   endtask

   // ---------------- model: packet rules over cycle timestamps ----------------
   int         m_cyc = 0;
   int         m_pos = 0;
   int         m_last_byte = 0;
   int         m_last_acc = 0;
   logic [3:0] m_cmd = 4'h0;
   logic       m_prev_done = 1'b0;
   logic       m_left = 1'b0, m_right = 1'b0, m_fire = 1'b0, m_start = 1'b0;
   logic       m_link = 1'b0, m_ok = 1'b0, m_err = 1'b0, m_prev_fire = 1'b0;
   logic       m_evt, m_acc;
   logic [7:0] m_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos = 0; m_cmd = 4'h0; m_prev_done = 1'b0;
         m_left = 1'b0; m_right = 1'b0; m_fire = 1'b0; m_start = 1'b0;
         m_link = 1'b0; m_ok = 1'b0; m_err = 1'b0; m_prev_fire = 1'b0;
      end else begin
         m_cyc++;
         m_ok = 1'b0; m_err = 1'b0; m_acc = 1'b0;
         m_evt = bus.i_rx_done && !m_prev_done;
         m_prev_done = bus.i_rx_done;
         m_b = bus.i_rx_data;
         if (m_evt) begin
            m_last_byte = m_cyc;
            if (m_pos == 0) begin
               if (m_b == SYNC) m_pos = 1;
            end else if (m_pos == 1) begin
               if (m_b == SYNC) m_pos = 1;
               else if (m_b[7:4] == 4'h0) begin m_cmd = m_b[3:0]; m_pos = 2; end
               else begin m_err = 1'b1; m_pos = 0; end
            end else begin
               if (m_b == ~{4'h0, m_cmd}) begin m_acc = 1'b1; m_pos = 0; end
               else begin m_err = 1'b1; m_pos = (m_b == SYNC) ? 1 : 0; end
            end
         end else if (m_pos != 0 && (m_cyc - m_last_byte) == BYTE_TO - 1) begin
            m_err = 1'b1; m_pos = 0;
         end
         if (m_acc) begin
            m_ok = 1'b1; m_link = 1'b1; m_last_acc = m_cyc;
            m_left  = m_cmd[0] && !m_cmd[1];
            m_right = m_cmd[1] && !m_cmd[0];
            m_start = m_cmd[3];
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
            m_fire = m_cmd[2] && !m_prev_fire;
            m_prev_fire = m_cmd[2];
`else
            m_fire = m_cmd[2];
`endif
         end else if (m_link && (m_cyc - m_last_acc) == HOLD_TO) begin
            m_link = 1'b0; m_left = 1'b0; m_right = 1'b0; m_fire = 1'b0; m_start = 1'b0;
            m_prev_fire = 1'b0;
         end else begin
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
            m_fire = 1'b0;
`endif
         end
      end
   end

   // ---------------- compare / scoreboard ----------------
   logic [7:0] sb_cmd;

   always @(posedge clk) begin
      #1;
      if (rst_n && chk_en) begin
         check("cycle",
               {7'h0, bus.o_pkt_err, bus.o_pkt_ok, bus.o_link_up, bus.o_start,
                bus.o_fire, bus.o_right, bus.o_left, dbg_state},
               {7'h0, m_err, m_ok, m_link, m_start, m_fire, m_right, m_left, 2'(m_pos)});
         check("ok_err_excl", 16'(bus.o_pkt_ok & bus.o_pkt_err), 16'h0);
         if (bus.o_pkt_ok) begin
            ok_cnt++;
            last_ok_cyc = tb_cyc;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_ok", 16'h1, 16'h0);
            end else begin
               sb_cmd = exp_q.pop_front();
               check("sb_ctrl", 16'(ctrl_vec() & CTRL_MASK),
                     16'({1'b1, sb_cmd[3], sb_cmd[2], sb_cmd[1] & ~sb_cmd[0],
                          sb_cmd[0] & ~sb_cmd[1]} & CTRL_MASK));
            end
         end
         if (bus.o_pkt_err) err_cnt++;
         if (bus.o_fire) fire_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      last_evt_cyc  = tb_cyc + 1;
      repeat (2) @(negedge clk);
      bus.i_rx_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [7:0] k, input bit exp_ok);
      send_byte(SYNC);
      send_byte(c);
      if (exp_ok) exp_q.push_back(c);
      send_byte(k);
   endtask

   task automatic wait_cyc(input int target);
      int g = 0;
      while (tb_cyc < target && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
   endtask

   // ---------------- directed sequence ----------------
   int n_ok, n_err, n_fire, s;

   initial begin
      bus.i_rx_data = 8'h00;
      bus.i_rx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {7'h0, bus.o_pkt_err, bus.o_pkt_ok, ctrl_vec(), dbg_state}, 16'h0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      n_ok = ok_cnt;
      send_pkt(8'h01, 8'hFE, 1'b1);
      check("ok_once_01", 16'(ok_cnt - n_ok), 16'd1);
      check("ok_latency", 16'(last_ok_cyc - last_evt_cyc), 16'd0);
      check_ctrl("ctrl_01", 5'b10001);

      n_ok = ok_cnt;
      send_pkt(8'h03, 8'hFC, 1'b1);
      check("ok_once_03", 16'(ok_cnt - n_ok), 16'd1);
      check_ctrl("ctrl_03_conflict", 5'b10000);

      send_pkt(8'h0C, 8'hF3, 1'b1);
      check_ctrl("ctrl_0c", 5'b11100);

      n_ok = ok_cnt; n_err = err_cnt;
      send_pkt(8'h04, 8'h00, 1'b0);
      check("bad_chk_err", 16'(err_cnt - n_err), 16'd1);
      check("bad_chk_no_ok", 16'(ok_cnt - n_ok), 16'd0);
      check_ctrl("bad_chk_ctrl_held", 5'b11100);

      n_err = err_cnt;
      send_byte(SYNC);
      send_byte(SYNC);
      send_byte(8'h02);
      exp_q.push_back(8'h02);
      send_byte(8'hFD);
      check("resync_no_err", 16'(err_cnt - n_err), 16'd0);
      check_ctrl("resync_ctrl", 5'b10010);

      send_byte(SYNC);
      s = last_evt_cyc;
      wait_cyc(s + 48);
      check("to_not_early", 16'(bus.o_pkt_err), 16'd0);
      check("to_state_sync", 16'(dbg_state), 16'd1);
      wait_cyc(s + 49);
      check("to_err", 16'(bus.o_pkt_err), 16'd1);
      check("to_idle", 16'(dbg_state), 16'd0);
      check_ctrl("to_ctrl_held", 5'b10010);
      send_pkt(8'h08, 8'hF7, 1'b1);
      check_ctrl("ctrl_08", 5'b11000);

      n_err = err_cnt;
      send_byte(SYNC);
      s = last_evt_cyc;
      wait_cyc(s + 48);
      send_byte(8'h05);
      check("edge_byte_at_expiry", 16'(last_evt_cyc - s), 16'd49);
      exp_q.push_back(8'h05);
      send_byte(8'hFA);
      check("edge_byte_wins", 16'(err_cnt - n_err), 16'd0);
      check_ctrl("ctrl_05", 5'b10101);

      n_err = err_cnt;
      send_byte(SYNC);
      send_byte(8'h12);
      check("upper_nibble_err", 16'(err_cnt - n_err), 16'd1);
      check("upper_nibble_idle", 16'(dbg_state), 16'd0);

      n_err = err_cnt;
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(SYNC);
      send_byte(8'h02);
      exp_q.push_back(8'h02);
      send_byte(8'hFD);
      check("sync_as_chk_err", 16'(err_cnt - n_err), 16'd1);
      check_ctrl("sync_as_chk_ctrl", 5'b10010);

      wait_cyc(last_ok_cyc + 199);
      check_ctrl("hold_still_up", 5'b10010);
      wait_cyc(last_ok_cyc + 200);
      check_ctrl("hold_released", 5'b00000);

      send_pkt(8'h0D, 8'hF2, 1'b1);
      check_ctrl("ctrl_0d", 5'b11101);
      send_byte(SYNC);
      send_byte(8'h01);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset",
            {7'h0, bus.o_pkt_err, bus.o_pkt_ok, ctrl_vec(), dbg_state}, 16'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_ok = ok_cnt;
      send_byte(8'hFE);
      check("partial_discarded", 16'(ok_cnt - n_ok), 16'd0);
      check("partial_idle", 16'(dbg_state), 16'd0);

      n_fire = fire_cnt;
      send_pkt(8'h04, 8'hFB, 1'b1);
      send_pkt(8'h04, 8'hFB, 1'b1);
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
      check("fire_one_pulse", 16'(fire_cnt - n_fire), 16'd1);
`else
      check("fire_level", 16'(bus.o_fire), 16'd1);
`endif
      wait_cyc(last_ok_cyc + 201);
      check_ctrl("fire_hold_released", 5'b00000);
      send_pkt(8'h04, 8'hFB, 1'b1);
`ifdef BT_CMD_CTRL_FIRE_PULSE_EN
      check("fire_second_pulse", 16'(fire_cnt - n_fire), 16'd2);
`else
      check("fire_level_again", 16'(bus.o_fire), 16'd1);
`endif
      check_ctrl("ctrl_04", 5'b10100);

      repeat (3) @(negedge clk);
      check("exp_q_empty", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bt_cmd_ctrl.md
Name: bt_cmd_ctrl

Overview:
Command sequencer between the Bluetooth `uart_rx` byte stream and the Space Arcade game logic. It frames incoming bytes into 3-byte packets, validates them, and drives held player-control levels (left/right/fire/start). It also supervises link liveness with inter-byte and hold timeouts. It sits directly downstream of `uart_rx` and replaces ad-hoc byte compares in top-level logic.

Parameters:
- SYNC_BYTE, 8'hA5: packet start marker.
- BYTE_TO_CYC, 120000: max clocks between bytes of one packet (10 ms at 12 MHz).
- HOLD_TO_CYC, 1200000: max clocks between valid packets before controls release (100 ms at 12 MHz).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  byte from `uart_rx` `o_data`; valid while `i_rx_done` is high.
- i_rx_done  in  1  `uart_rx` `o_done`; synchronous to i_clk; may stay high more than one cycle.
- o_left  out  1  held left control.
- o_right  out  1  held right control.
- o_fire  out  1  fire control (see Optional Feature).
- o_start  out  1  held start control.
- o_link_up  out  1  high while valid packets arrive within HOLD_TO_CYC.
- o_pkt_ok  out  1  one-cycle pulse per accepted packet.
- o_pkt_err  out  1  one-cycle pulse per rejected packet or inter-byte timeout.

Behaviour:
- Reset: async assert on `i_rst_n` low. All outputs are 0, FSM is IDLE, counters are 0, and the done-edge register is 0. Release is synchronous to i_clk.
- Byte event: `i_rx_done`=1 this cycle and the registered previous sample =0. At most one byte event per done assertion. `i_rx_data` is sampled in the event cycle.
- Packet format: SYNC_BYTE, CMD, CHK.
  - CHK must equal ~CMD.
  - CMD[0] is left, CMD[1] is right, CMD[2] is fire, CMD[3] is start.
  - CMD[7:4] must be 0.
- FSM states: IDLE, GOT_SYNC, GOT_CMD.
- IDLE:
  - Byte == SYNC_BYTE goes to GOT_SYNC.
  - Any other byte is discarded silently (no err pulse).
- GOT_SYNC:
  - Byte == SYNC_BYTE stays in GOT_SYNC (resync, no err).
  - Byte with [7:4]==0 is latched as CMD; go to GOT_CMD.
  - Byte with [7:4]!=0: `o_pkt_err` pulse; go to IDLE.
- GOT_CMD:
  - Byte == ~CMD: packet accepted; go to IDLE.
  - Otherwise: `o_pkt_err` pulse. Go to GOT_SYNC if byte == SYNC_BYTE, else IDLE.
- Accept actions, all registered, visible on the clock edge after the CHK byte-event cycle (1-cycle latency):
  - `o_pkt_ok`=1 for one cycle.
  - `o_link_up`=1.
  - Hold counter cleared.
  - Controls loaded from CMD. If CMD[0] and CMD[1] are both 1, `o_left`=`o_right`=0 (conflict cancels); other bits apply normally.
- Inter-byte timer:
  - Counts in GOT_SYNC and GOT_CMD; cleared on every byte event and in IDLE.
  - Reaching BYTE_TO_CYC-1 without a byte: `o_pkt_err` pulse; go to IDLE. Controls are unchanged.
- Hold timer:
  - Counts every cycle while `o_link_up`=1; cleared on accept.
  - Reaching HOLD_TO_CYC-1: on the next edge, all four controls =0 and `o_link_up`=0. Counter stops at 0 until the next accept.
- Simultaneous events: a byte event in the same cycle the inter-byte timer expires is processed as a byte; the timeout is ignored. An accept in the same cycle the hold timer expires wins; controls load from CMD.
- `o_pkt_ok` and `o_pkt_err` are never high in the same cycle.
- Counter widths: $clog2 of the respective parameter. No wrap: counters saturate at their terminal value.
- Reset mid-packet discards the partial packet; controls drop immediately (async).

Optional Feature:
- Macro: BT_CMD_CTRL_FIRE_PULSE_EN.
- Defined: `o_fire` is a one-cycle pulse, issued on an accept where CMD[2]=1 and the previously accepted CMD[2]=0. The stored previous fire bit clears on hold timeout and on reset, so a repeated fire after link loss pulses again.
- Undefined: `o_fire` is a held level like the other controls.

Test Plan:
- Send A5,01,FE with 2-cycle done pulses -> `o_left`=1, others 0; `o_pkt_ok` pulses exactly once, 1 cycle after the FE byte event; `o_link_up`=1.
- Send A5,03,FC -> `o_left`=`o_right`=0, `o_pkt_ok` pulse. Send A5,0C,F3 -> `o_fire`=`o_start`=1 (level build).
- Send A5,04,00 (bad CHK) -> one `o_pkt_err`, controls unchanged. Send A5,A5,02,FD -> no err, accept, `o_right`=1.
- Send A5, then nothing for BYTE_TO_CYC cycles (set 50 in bench) -> `o_pkt_err` at cycle 49 after the byte; FSM back in IDLE; next A5,08,F7 accepted.
- Accept A5,02,FD, then idle HOLD_TO_CYC (set 200) -> after 200 cycles all controls and `o_link_up` =0. Assert `i_rst_n`=0 mid-packet -> all outputs 0 asynchronously.
- With BT_CMD_CTRL_FIRE_PULSE_EN: send A5,04,FB twice -> one `o_fire` pulse total. Then hold timeout, then A5,04,FB -> second pulse.
